// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_port_arbiter.
// The slave modport is the arbiter's view. The master modport is the view
// used by whatever drives the requesters and models the memory.
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  // core requester
  logic            core_req;
  logic            core_we;
  logic [XLEN-1:0] core_addr;
  logic [XLEN-1:0] core_wdata;
  logic [XLEN-1:0] core_rdata;
  logic            core_done;
  logic            core_stall;
  // loader requester
  logic            ldr_req;
  logic            ldr_we;
  logic [XLEN-1:0] ldr_addr;
  logic [XLEN-1:0] ldr_wdata;
  logic [XLEN-1:0] ldr_rdata;
  logic            ldr_done;
  // memory side
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_done, core_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_done,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_done, core_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_done,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between the pipeline MEM stage (core)
// and the program/data loader (ldr). Each access runs IDLE -> ACCESS
// (LATENCY cycles) -> RESP (one cycle). Core has fixed priority, but after
// STARVE_LIMIT contended core wins the loader is granted.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_starve;
  logic            r_owner_ldr;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_core_rdata;
  logic [XLEN-1:0] r_ldr_rdata;

  logic w_idle;
  logic w_access;
  logic w_any_req;
  logic w_grant_ldr;
  logic w_last_access;

  assign w_idle        = (r_state == S_IDLE);
  assign w_access      = (r_state == S_ACCESS);
  assign w_any_req     = bus.core_req | bus.ldr_req;
  // Loader wins when it is alone, or when core has starved it long enough.
  assign w_grant_ldr   = bus.ldr_req & (~bus.core_req | (r_starve >= STARVE_MAX));
  assign w_last_access = w_access & (r_cnt == '0);

  // Sequencing FSM: IDLE -> ACCESS (down-counter) -> RESP -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_ACCESS;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Latch the winner's operands at grant; requester inputs are ignored until the next IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_ldr <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else if (w_idle && w_any_req) begin
      r_owner_ldr <= w_grant_ldr;
      r_we        <= w_grant_ldr ? bus.ldr_we    : bus.core_we;
      r_addr      <= w_grant_ldr ? bus.ldr_addr  : bus.core_addr;
      r_wdata     <= w_grant_ldr ? bus.ldr_wdata : bus.core_wdata;
    end
  end

  // Count core grants made while the loader was waiting; saturates, clears on a loader grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_idle && w_any_req) begin
      if (w_grant_ldr) begin
        r_starve <= '0;
      end else if (bus.ldr_req && (r_starve != STARVE_MAX)) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  // Capture memory read data into the owner's register on the last ACCESS edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_rdata <= '0;
      r_ldr_rdata  <= '0;
    end else if (w_last_access && !r_we) begin
      if (r_owner_ldr) begin
        r_ldr_rdata <= bus.mem_rdata;
      end else begin
        r_core_rdata <= bus.mem_rdata;
      end
    end
  end

  // The write strobe fires only in the first ACCESS cycle so each write lands exactly once.
  assign bus.mem_we     = w_access & (r_cnt == CNT_LOAD) & r_we;
  assign bus.mem_addr   = w_access ? r_addr  : '0;
  assign bus.mem_wdata  = w_access ? r_wdata : '0;

  assign bus.core_done  = (r_state == S_RESP) & ~r_owner_ldr;
  assign bus.ldr_done   = (r_state == S_RESP) &  r_owner_ldr;
  assign bus.core_rdata = r_core_rdata;
  assign bus.ldr_rdata  = r_ldr_rdata;
  assign bus.core_stall = bus.core_req & ~bus.core_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Two instances: LATENCY=2 with
// STARVE_LIMIT=2, and LATENCY=1 for back-to-back timing. Each has a small
// word-addressed memory model. Expected read data comes from a shadow copy
// of that memory and is queued when a request is driven.
module tb_mem_port_arbiter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] mem   [0:63];
  logic [31:0] mem1  [0:63];
  logic [31:0] model [0:63];
  logic [31:0] model1[0:63];
  logic [31:0] exp_core_q[$];
  logic [31:0] exp_ldr_q[$];
  bit          exp_owner_q[$];
  logic [31:0] exp_ldr_rdata;

  mem_port_arbiter_if #(.XLEN(XLEN)) bus ();
  mem_port_arbiter_if #(.XLEN(XLEN)) bus1 ();

  mem_port_arbiter #(.XLEN(XLEN), .LATENCY(2), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  mem_port_arbiter #(.XLEN(XLEN), .LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    if (bus1.mem_we === 1'b1) mem1[bus1.mem_addr[7:2]] <= bus1.mem_wdata;
  end
  assign bus.mem_rdata  = mem[bus.mem_addr[7:2]];
  assign bus1.mem_rdata = mem1[bus1.mem_addr[7:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_ldr_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_checks++; if (bus.core_done !== 1'b0 || bus.ldr_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got core=%b ldr=%b want 0 0", bus.core_done, bus.ldr_done); end
    n_checks++; if (bus.core_rdata !== 32'h0 || bus.ldr_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got core=%h ldr=%h want 0 0", bus.core_rdata, bus.ldr_rdata); end
    n_checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem: got we=%b addr=%h wdata=%h want 0 0 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    n_checks++; if (bus1.core_done !== 1'b0 || bus1.mem_we !== 1'b0 || bus1.core_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_dut1: got done=%b we=%b rdata=%h want 0 0 0", bus1.core_done, bus1.mem_we, bus1.core_rdata); end
    tick();
    rst = 1'b0;
    exp_ldr_rdata = '0;
    $display("reset: checked registered outputs after reset");
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if ({bus.mem_we, bus.mem_addr, bus.core_done, bus.ldr_done, bus.core_stall} !== 35'h0) begin
        n_fail++;
        $display("FAIL idle_c%0d: got we=%b addr=%h cdone=%b ldone=%b stall=%b want all 0",
                 c, bus.mem_we, bus.mem_addr, bus.core_done, bus.ldr_done, bus.core_stall);
      end
    end
    $display("idle: 10 cycles with no requests");
  endtask

  task automatic test_core_read();
    logic [31:0] want;
    mem[4] <= 32'hDEADBEEF;
    model[4] = 32'hDEADBEEF;
    tick();
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h10; bus.core_wdata = 32'h0;
    exp_core_q.push_back(model[4]);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (bus.core_stall !== 1'(c < 3)) begin n_fail++; $display("FAIL core_read_stall_c%0d: got %b want %b", c, bus.core_stall, c < 3); end
      n_checks++; if (bus.core_done !== 1'(c == 3)) begin n_fail++; $display("FAIL core_read_done_c%0d: got %b want %b", c, bus.core_done, c == 3); end
      if (c == 1 || c == 2) begin
        n_checks++; if (bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL core_read_mem_c%0d: got addr=%h we=%b want 10 0", c, bus.mem_addr, bus.mem_we); end
      end
      if (c == 3) begin
        want = exp_core_q.pop_front();
        n_checks++; if (bus.core_rdata !== want) begin n_fail++; $display("FAIL core_read_rdata: got %h want %h", bus.core_rdata, want); end
      end
      tick();
    end
    bus.core_req = 1'b0;
    $display("core_read: addr 10 data %h", model[4]);
  endtask

  task automatic test_ldr_write();
    int pulses = 0;
    bit seen = 0;
    logic [31:0] want;
    tick();
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 32'h20; bus.ldr_wdata = 32'h12345678;
    model[8] = 32'h12345678;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) begin
        pulses++;
        n_checks++; if (bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL ldr_write_bus: got addr=%h wdata=%h want 20 12345678", bus.mem_addr, bus.mem_wdata); end
      end
      n_checks++; if (bus.ldr_done !== 1'(c == 3) || bus.core_done !== 1'b0) begin n_fail++; $display("FAIL ldr_write_done_c%0d: got ldr=%b core=%b want %b 0", c, bus.ldr_done, bus.core_done, c == 3); end
      if (c == 3) begin
        n_checks++; if (bus.ldr_rdata !== exp_ldr_rdata) begin n_fail++; $display("FAIL ldr_write_rdata: got %h want %h", bus.ldr_rdata, exp_ldr_rdata); end
      end
      tick();
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL ldr_write_pulses: got %0d want 1", pulses); end
    // read the word back through the loader port
    bus.ldr_we = 1'b0;
    exp_ldr_q.push_back(model[8]);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.ldr_done === 1'b1) begin
        seen = 1;
        want = exp_ldr_q.pop_front();
        exp_ldr_rdata = want;
        n_checks++; if (bus.ldr_rdata !== want) begin n_fail++; $display("FAIL ldr_readback: got %h want %h", bus.ldr_rdata, want); end
      end
      tick();
    end
    bus.ldr_req = 1'b0;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL ldr_readback_timeout: got no done want done within 10 cycles"); end
    $display("ldr_write: addr 20 data 12345678, pulses %0d", pulses);
  endtask

  task automatic test_starvation();
    int grants = 0;
    bit want_ldr;
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < 6; i++) exp_owner_q.push_back(i == 2 || i == 5);
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h40;
    bus.ldr_req  = 1'b1; bus.ldr_we  = 1'b0; bus.ldr_addr  = 32'h44;
    for (int c = 0; c < 60 && grants < 6; c++) begin
      @(negedge clk);
      if (bus.core_done === 1'b1 || bus.ldr_done === 1'b1) begin
        want_ldr = exp_owner_q.pop_front();
        n_checks++; if (bus.ldr_done !== want_ldr || bus.core_done !== !want_ldr) begin n_fail++; $display("FAIL starve_grant%0d: got core=%b ldr=%b want ldr=%b", grants, bus.core_done, bus.ldr_done, want_ldr); end
        want = want_ldr ? model[17] : model[16];
        n_checks++; if ((want_ldr ? bus.ldr_rdata : bus.core_rdata) !== want) begin n_fail++; $display("FAIL starve_rdata%0d: got %h want %h", grants, want_ldr ? bus.ldr_rdata : bus.core_rdata, want); end
        if (want_ldr) begin
          n_checks++; if (bus.core_stall !== 1'b1) begin n_fail++; $display("FAIL starve_core_stall%0d: got %b want 1", grants, bus.core_stall); end
        end
        $display("starvation: grant %0d to %s", grants, bus.ldr_done ? "ldr" : "core");
        grants++;
      end
      tick();
    end
    bus.core_req = 1'b0;
    bus.ldr_req  = 1'b0;
    exp_ldr_rdata = model[17];
    n_checks++; if (grants != 6) begin n_fail++; $display("FAIL starve_timeout: got %0d grants want 6", grants); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    logic [31:0] want;
    tick();
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'h30; bus.core_wdata = 32'hAAAA5555;
    model[12] = 32'hAAAA5555;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_we_first: got %b want 1", bus.mem_we); end
    tick();
    rst = 1'b1;
    bus.core_req = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if ({bus.core_done, bus.core_stall, bus.mem_we} !== 3'b000) begin n_fail++; $display("FAIL rstmid_ctrl: got done=%b stall=%b we=%b want 0 0 0", bus.core_done, bus.core_stall, bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_mem: got addr=%h wdata=%h want 0 0", bus.mem_addr, bus.mem_wdata); end
    n_checks++; if (bus.core_rdata !== 32'h0 || bus.ldr_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got core=%h ldr=%h want 0 0", bus.core_rdata, bus.ldr_rdata); end
    rst = 1'b0;
    exp_ldr_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      n_checks++; if (bus.core_done !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet_c%0d: got done=%b we=%b want 0 0", c, bus.core_done, bus.mem_we); end
    end
    tick();
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h30;
    exp_core_q.push_back(model[12]);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.core_done === 1'b1) begin
        seen = 1;
        want = exp_core_q.pop_front();
        n_checks++; if (bus.core_rdata !== want) begin n_fail++; $display("FAIL rstmid_after_rdata: got %h want %h", bus.core_rdata, want); end
      end
      tick();
    end
    bus.core_req = 1'b0;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_after_timeout: got no done want done within 10 cycles"); end
    $display("reset_mid: write abandoned, follow-up read of 30 done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    mem1[0] <= 32'h11110000; model1[0] = 32'h11110000;
    mem1[1] <= 32'h22220004; model1[1] = 32'h22220004;
    tick();
    bus1.core_req = 1'b1; bus1.core_we = 1'b0; bus1.core_addr = 32'h0; bus1.core_wdata = 32'h0;
    exp_core_q.push_back(model1[0]);
    exp_core_q.push_back(model1[1]);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_checks++; if (bus1.core_done !== 1'(c == 2 || c == 5)) begin n_fail++; $display("FAIL b2b_done_c%0d: got %b want %b", c, bus1.core_done, c == 2 || c == 5); end
      n_checks++; if (bus1.core_stall !== 1'(c <= 5 && c != 2 && c != 5)) begin n_fail++; $display("FAIL b2b_stall_c%0d: got %b want %b", c, bus1.core_stall, c <= 5 && c != 2 && c != 5); end
      if (c == 2 || c == 5) begin
        want = exp_core_q.pop_front();
        n_checks++; if (bus1.core_rdata !== want) begin n_fail++; $display("FAIL b2b_rdata_c%0d: got %h want %h", c, bus1.core_rdata, want); end
        $display("back_to_back: done at cycle %0d rdata %h", c, bus1.core_rdata);
      end
      tick();
      if (c == 2) bus1.core_addr = 32'h4;
      if (c == 5) bus1.core_req = 1'b0;
    end
  endtask

  initial begin
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.ldr_req  = 1'b0; bus.ldr_we  = 1'b0; bus.ldr_addr  = '0; bus.ldr_wdata  = '0;
    bus1.core_req = 1'b0; bus1.core_we = 1'b0; bus1.core_addr = '0; bus1.core_wdata = '0;
    bus1.ldr_req  = 1'b0; bus1.ldr_we  = 1'b0; bus1.ldr_addr  = '0; bus1.ldr_wdata  = '0;
    exp_ldr_rdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]    <= 32'hA500_0000 | 32'(i);
      model[i]   = 32'hA500_0000 | 32'(i);
      mem1[i]   <= 32'h5A00_0000 | 32'(i);
      model1[i]  = 32'h5A00_0000 | 32'(i);
    end
    test_reset();
    test_idle();
    test_core_read();
    test_ldr_write();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
